// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined parallel-prefix adder family.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned pfx_levels(input int unsigned width);
    return clog2(width);
  endfunction

  // One operand register plus one register per group of lps prefix levels.
  function automatic int unsigned pipe_lat(input int unsigned width, input int unsigned lps);
    return 1 + (pfx_levels(width) + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/pfx_level.sv
// One combinational Kogge-Stone level: combine each node with the node SPAN below it.
module pfx_level
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SPAN  = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  always_comb begin
    g_out = g_in;
    p_out = p_in;
    for (int unsigned i = SPAN; i < WIDTH; i++) begin
      g_out[i] = g_in[i] | (p_in[i] & g_in[i-SPAN]);
      p_out[i] = p_in[i] & p_in[i-SPAN];
    end
  end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshakes and tag passthrough.
module prefix_adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LPS   = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned L  = pfx_levels(WIDTH);
  localparam int unsigned NG = (L + LPS - 1) / LPS;

  logic             advance;
  logic [WIDTH-1:0] bb;
  logic             c0;

  logic [WIDTH-1:0] st_g   [NG];
  logic [WIDTH-1:0] st_p   [NG];
  logic [WIDTH-1:0] st_x   [NG];
  logic             st_c0  [NG];
  logic             st_am  [NG];
  logic             st_bm  [NG];
  logic             st_v   [NG];
  logic [TAG_W-1:0] st_tag [NG];

  logic [WIDTH-1:0] in_g [L];
  logic [WIDTH-1:0] in_p [L];
  logic [WIDTH-1:0] lv_g [L];
  logic [WIDTH-1:0] lv_p [L];

  logic [WIDTH-1:0] fin_g;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    bb = (op_e'(op_sub) == OP_SUB) ? ~b : b;
    c0 = cin ^ op_sub;
  end

  // Carry-in is folded into bit 0's generate at the first level, so every
  // prefix G[i] already is the carry out of bit i.
  for (genvar k = 0; k < L; k++) begin : g_lvl
    if (k == 0) begin : g_first
      assign in_g[k] = {st_g[0][WIDTH-1:1], st_g[0][0] | (st_p[0][0] & st_c0[0])};
      assign in_p[k] = st_p[0];
    end else if ((k % LPS) == 0) begin : g_reg
      assign in_g[k] = st_g[k/LPS];
      assign in_p[k] = st_p[k/LPS];
    end else begin : g_chain
      assign in_g[k] = lv_g[k-1];
      assign in_p[k] = lv_p[k-1];
    end

    pfx_level #(
      .WIDTH (WIDTH),
      .SPAN  (1 << k)
    ) u_lvl (
      .g_in  (in_g[k]),
      .p_in  (in_p[k]),
      .g_out (lv_g[k]),
      .p_out (lv_p[k])
    );
  end

  always_comb begin
    fin_g  = lv_g[L-1];
    sum_d  = st_x[NG-1] ^ {fin_g[WIDTH-2:0], st_c0[NG-1]};
    cout_d = fin_g[WIDTH-1];
    // Same-sign operands whose result sign differs: equals carry[W-1]^carry[W-2].
    ovf_d  = ~(st_am[NG-1] ^ st_bm[NG-1]) & (sum_d[WIDTH-1] ^ st_am[NG-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < NG; j++) begin
        st_g[j]   <= '0;
        st_p[j]   <= '0;
        st_x[j]   <= '0;
        st_c0[j]  <= 1'b0;
        st_am[j]  <= 1'b0;
        st_bm[j]  <= 1'b0;
        st_v[j]   <= 1'b0;
        st_tag[j] <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      tag_out   <= '0;
    end else if (advance) begin
      st_v[0] <= in_valid;
      if (in_valid) begin
        st_g[0]   <= a & bb;
        st_p[0]   <= a | bb;
        st_x[0]   <= a ^ bb;
        st_c0[0]  <= c0;
        st_am[0]  <= a[WIDTH-1];
        st_bm[0]  <= bb[WIDTH-1];
        st_tag[0] <= tag_in;
      end
      for (int unsigned j = 1; j < NG; j++) begin
        st_v[j] <= st_v[j-1];
        if (st_v[j-1]) begin
          st_g[j]   <= lv_g[j*LPS-1];
          st_p[j]   <= lv_p[j*LPS-1];
          st_x[j]   <= st_x[j-1];
          st_c0[j]  <= st_c0[j-1];
          st_am[j]  <= st_am[j-1];
          st_bm[j]  <= st_bm[j-1];
          st_tag[j] <= st_tag[j-1];
        end
      end
      out_valid <= st_v[NG-1];
      // Bubbles leave the output fields at their last held value.
      if (st_v[NG-1]) begin
        sum     <= sum_d;
        cout    <= cout_d;
        ovf     <= ovf_d;
        zero    <= (sum_d == '0);
        tag_out <= st_tag[NG-1];
      end
    end
  end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Scoreboard bench for prefix_adder_pipe: directed corner cases, stall, reset and random traffic.
module tb_prefix_adder_pipe;

  localparam int unsigned W   = 32;
  localparam int unsigned LPS = 2;
  localparam int unsigned TW  = 4;
  localparam int unsigned LAT = 1 + ($clog2(W) + LPS - 1) / LPS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          op_sub = 1'b0;
  logic [TW-1:0] tag_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic          zero;
  logic [TW-1:0] tag_out;

  prefix_adder_pipe #(
    .WIDTH (W),
    .LPS   (LPS),
    .TAG_W (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic [TW-1:0] tag;
    int unsigned   cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          mode = 0;
  int unsigned base = 0;
  bit          lat_chk = 0;
  bit          held = 0;
  logic [W+TW+2:0] hold_v;

  always @(posedge clk) cyc <= cyc + 1;

  // Arithmetic reference: plain integer add/sub, overflow from the exact signed result.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sub, input logic [TW-1:0] t);
    exp_t e;
    logic [W+1:0]        u;
    logic signed [W+1:0] sx, sy, sc, s;
    sx = $signed({{2{x[W-1]}}, x});
    sy = $signed({{2{y[W-1]}}, y});
    sc = $signed({{(W+1){1'b0}}, ci});
    if (!sub) begin
      u      = {2'b00, x} + {2'b00, y} + {{(W+1){1'b0}}, ci};
      e.cout = u[W];
      s      = sx + sy + sc;
    end else begin
      u      = {2'b00, x} - {2'b00, y} - {{(W+1){1'b0}}, ci};
      e.cout = ({1'b0, x} >= ({1'b0, y} + {{W{1'b0}}, ci}));
      s      = sx - sy - sc;
    end
    e.sum  = u[W-1:0];
    e.ovf  = (s[W+1:W-1] != 3'b000) && (s[W+1:W-1] != 3'b111);
    e.zero = (e.sum == '0);
    e.tag  = t;
    e.cyc  = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return $urandom;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    case (mode)
      1:       out_ready = ($urandom % 4) != 0;
      2:       out_ready = !((cyc - base) >= 5 && (cyc - base) <= 7);
      3:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one beat and pushes its expected result once the handshake is seen.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic sub, input logic [TW-1:0] t);
    int   n;
    exp_t e;
    n = 0;
    a = x; b = y; cin = ci; op_sub = sub; tag_in = t; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (mode == 2)
        chk("stall_in_ready", {{(W-1){1'b0}}, in_ready},
            {{(W-1){1'b0}}, !((cyc - base) >= 5 && (cyc - base) <= 7)});
      if (in_ready) begin
        e = model(x, y, ci, sub, t);
        e.cyc = cyc;
        exp_q.push_back(e);
        break;
      end
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 0;
    end else begin
      if (held) begin
        checks++;
        if (!out_valid || {sum, cout, ovf, zero, tag_out} !== hold_v) begin
          errors++;
          $display("FAIL hold_stable: got v=%b %h required v=1 %h", out_valid,
                   {sum, cout, ovf, zero, tag_out}, hold_v);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out: got sum=%h tag=%h with no beat outstanding", sum, tag_out);
        end else begin
          e = exp_q.pop_front();
          if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf || zero !== e.zero || tag_out !== e.tag) begin
            errors++;
            $display("FAIL result: got sum=%h c=%b v=%b z=%b tag=%h required sum=%h c=%b v=%b z=%b tag=%h",
                     sum, cout, ovf, zero, tag_out, e.sum, e.cout, e.ovf, e.zero, e.tag);
          end
          if (lat_chk) begin
            checks++;
            if (cyc - e.cyc != LAT) begin
              errors++;
              $display("FAIL latency: got %0d required %0d", cyc - e.cyc, LAT);
            end
          end
        end
      end
      held   = out_valid && !out_ready;
      hold_v = {sum, cout, ovf, zero, tag_out};
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding required 0", exp_q.size());
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
    chk("rst_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    chk("rst_sum", sum, '0);
    chk("rst_flags", {{(W-3){1'b0}}, cout, ovf, zero}, '0);
    chk("rst_tag", {{(W-TW){1'b0}}, tag_out}, '0);
    @(posedge clk);
    #1;

    // Directed corners, back-to-back with out_ready held high.
    lat_chk = 1;
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd3);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd4);
    issue(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 4'd5);
    issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 4'd6);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'd7);
    issue(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 4'd8);
    drain();
    lat_chk = 0;
    idle(2);

    // Eight-beat stream with a three-cycle downstream stall.
    base = cyc + 1;
    mode = 2;
    idle(1);
    for (int i = 0; i < 8; i++) issue(pick(), pick(), 1'($urandom), 1'($urandom), TW'(i));
    mode = 0;
    drain();
    idle(2);

    // Reset while the pipeline holds beats behind a stalled output.
    mode = 3;
    idle(1);
    for (int i = 0; i < 4; i++) issue(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, TW'(i + 1));
    idle(1);
    chk("pre_rst_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", {{(W-1){1'b0}}, out_valid}, '0);
    chk("mid_rst_sum", sum, '0);
    chk("mid_rst_flags", {{(W-3){1'b0}}, cout, ovf, zero}, '0);
    chk("mid_rst_tag", {{(W-TW){1'b0}}, tag_out}, '0);
    chk("mid_rst_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
    mode = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {{(W-1){1'b0}}, out_valid}, '0);
    end
    @(posedge clk);
    #1;

    // Random traffic with random gaps and random backpressure.
    mode = 1;
    for (int i = 0; i < 3000; i++) begin
      issue(pick(), pick(), 1'($urandom), 1'($urandom), TW'($urandom));
      if (($urandom % 3) == 0) idle($urandom_range(1, 3));
    end
    mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
